// File: rtl/gan_batch_sequencer.sv
// gan_batch_sequencer: run controller that loads weights from a word stream, gathers noise
//   samples, fires the generator once per sample, waits for the discriminator, streams out pixels+score.
// Latency: last z handshake -> FIRE next cycle -> WAIT; first res_valid one cycle after disc_done.
// Backpressure: cfg/z/res are valid-ready; res_data/res_valid hold while res_ready is low.
//
// Ports:
//   cfg_valid/cfg_ready/cfg_data  weight words, order G1, G2, D1, D2, index 0 first
//   z_valid/z_ready/z_data        noise words, z1 first
//   gen_valid_in, gen_z           generator start pulse and packed noise (z1 at [DW-1:0])
//   flat_weights_*                packed weight buses, word i at [DW*i +: DW]
//   gen_pix, disc_done, disc_score  generator pixels and discriminator result
//   res_valid/res_ready/res_data/res_last  result stream, NPIX pixels then score
//   weights_loaded, busy, err_timeout, sample_cnt, score_sum  status
// Optional macro GAN_SCORE_SUM_EN: enables the score_sum accumulator (tied to 0 otherwise).
module gan_batch_sequencer #(
  parameter int DW      = 16,
  parameter int NZ      = 2,
  parameter int NPIX    = 9,
  parameter int N_G1    = 9,
  parameter int N_G2    = 36,
  parameter int N_D1    = 30,
  parameter int N_D2    = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DW-1:0]         cfg_data,
  input  logic                  z_valid,
  output logic                  z_ready,
  input  logic [DW-1:0]         z_data,
  output logic                  gen_valid_in,
  output logic [NZ*DW-1:0]      gen_z,
  output logic [N_G1*DW-1:0]    flat_weights_L1,
  output logic [N_G2*DW-1:0]    flat_weights_L2,
  output logic [N_D1*DW-1:0]    flat_weights_D1,
  output logic [N_D2*DW-1:0]    flat_weights_D2,
  input  logic [NPIX*DW-1:0]    gen_pix,
  input  logic                  disc_done,
  input  logic [DW-1:0]         disc_score,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DW-1:0]         res_data,
  output logic                  res_last,
  output logic                  weights_loaded,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [DW+CNT_W-1:0]   score_sum
);

  localparam int N_W = N_G1 + N_G2 + N_D1 + N_D2;
  localparam int IW  = $clog2(N_W + 1);
  localparam int ZW  = $clog2(NZ + 1);
  localparam int KW  = $clog2(NPIX + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_GATHER = 3'd2;
  localparam logic [2:0] S_FIRE   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_EMIT   = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [IW-1:0]            widx_q, widx_d;
  logic [N_W*DW-1:0]        wbus_q, wbus_d;
  logic                     wl_q, wl_d;
  logic [ZW-1:0]            zidx_q, zidx_d;
  logic [NZ*DW-1:0]         gz_q, gz_d;
  logic [TW-1:0]            tmr_q, tmr_d;
  logic [(NPIX+1)*DW-1:0]   rbuf_q, rbuf_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     err_q, err_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic cfg_hs, z_hs, res_hs;

  // cfg wins over z in IDLE, so a reload request never races a sample start.
  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign z_ready   = (state_q == S_GATHER) || ((state_q == S_IDLE) && wl_q && !cfg_valid);
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign z_hs      = z_valid && z_ready;
  assign res_valid = (state_q == S_EMIT);
  assign res_hs    = res_valid && res_ready;

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    wbus_d  = wbus_q;
    wl_d    = wl_q;
    zidx_d  = zidx_q;
    gz_d    = gz_q;
    tmr_d   = tmr_q;
    rbuf_d  = rbuf_q;
    k_d     = k_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_hs) begin
          // A new load invalidates the set; untouched words keep old values until rewritten.
          wl_d             = (N_W == 1);
          wbus_d[DW-1:0]   = cfg_data;
          widx_d           = IW'(1);
          if (N_W > 1) state_d = S_LOAD;
        end else if (z_hs) begin
          gz_d[DW-1:0] = z_data;
          zidx_d       = ZW'(1);
          state_d      = (NZ > 1) ? S_GATHER : S_FIRE;
        end
      end
      S_LOAD: begin
        if (cfg_hs) begin
          wbus_d[widx_q*DW +: DW] = cfg_data;
          widx_d = widx_q + IW'(1);
          if (widx_q == IW'(N_W - 1)) begin
            wl_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_GATHER: begin
        if (z_hs) begin
          gz_d[zidx_q*DW +: DW] = z_data;
          zidx_d = zidx_q + ZW'(1);
          if (zidx_q == ZW'(NZ - 1)) state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        // Checking done first makes it win over a same-cycle expiry.
        if (disc_done) begin
          rbuf_d  = {disc_score, gen_pix};
          cnt_d   = cnt_q + CNT_W'(1);
          k_d     = '0;
          state_d = S_EMIT;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (res_hs) begin
          if (k_q == KW'(NPIX)) state_d = S_IDLE;
          else                  k_d     = k_q + KW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      widx_q  <= '0;
      wbus_q  <= '0;
      wl_q    <= 1'b0;
      zidx_q  <= '0;
      gz_q    <= '0;
      tmr_q   <= '0;
      rbuf_q  <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      wbus_q  <= wbus_d;
      wl_q    <= wl_d;
      zidx_q  <= zidx_d;
      gz_q    <= gz_d;
      tmr_q   <= tmr_d;
      rbuf_q  <= rbuf_d;
      k_q     <= k_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef GAN_SCORE_SUM_EN
  logic [DW+CNT_W-1:0] ssum_q, ssum_d;
  logic                load_start, capture;

  assign load_start = (state_q == S_IDLE) && cfg_hs;
  assign capture    = (state_q == S_WAIT) && disc_done;

  always_comb begin
    ssum_d = ssum_q;
    if (load_start)   ssum_d = '0;
    else if (capture) ssum_d = ssum_q + {{CNT_W{disc_score[DW-1]}}, disc_score};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ssum_q <= '0;
    else        ssum_q <= ssum_d;
  end

  assign score_sum = ssum_q;
`else
  assign score_sum = '0;
`endif

  assign gen_valid_in    = (state_q == S_FIRE);
  assign gen_z           = gz_q;
  assign flat_weights_L1 = wbus_q[N_G1*DW-1:0];
  assign flat_weights_L2 = wbus_q[(N_G1+N_G2)*DW-1 : N_G1*DW];
  assign flat_weights_D1 = wbus_q[(N_G1+N_G2+N_D1)*DW-1 : (N_G1+N_G2)*DW];
  assign flat_weights_D2 = wbus_q[N_W*DW-1 : (N_G1+N_G2+N_D1)*DW];
  assign res_data        = rbuf_q[k_q*DW +: DW];
  assign res_last        = res_valid && (k_q == KW'(NPIX));
  assign weights_loaded  = wl_q;
  assign busy            = (state_q != S_IDLE);
  assign err_timeout     = err_q;
  assign sample_cnt      = cnt_q;

endmodule

// File: tb/tb_gan_batch_sequencer.sv
// tb_gan_batch_sequencer: randomized bench for gan_batch_sequencer against a word-level model.
// Latency: checks FIRE one cycle after the last z handshake and first result one cycle after disc_done.
// Backpressure: drives random and fixed res_ready stalls on the result stream.
module tb_gan_batch_sequencer;
  localparam int DW = 16, NZ = 2, NPIX = 9, N_G1 = 9, N_G2 = 36, N_D1 = 30, N_D2 = 4;
  localparam int CNT_W = 16, TMO = 8;
  localparam int N_W = N_G1 + N_G2 + N_D1 + N_D2;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_valid, cfg_ready, z_valid, z_ready;
  logic [DW-1:0] cfg_data, z_data, disc_score, res_data;
  logic gen_valid_in, disc_done, res_valid, res_ready, res_last;
  logic weights_loaded, busy, err_timeout;
  logic [NZ*DW-1:0] gen_z;
  logic [N_G1*DW-1:0] flat_weights_L1;
  logic [N_G2*DW-1:0] flat_weights_L2;
  logic [N_D1*DW-1:0] flat_weights_D1;
  logic [N_D2*DW-1:0] flat_weights_D2;
  logic [NPIX*DW-1:0] gen_pix;
  logic [CNT_W-1:0] sample_cnt;
  logic [DW+CNT_W-1:0] score_sum;

  always #5 clk = ~clk;

  gan_batch_sequencer #(.DW(DW), .NZ(NZ), .NPIX(NPIX), .N_G1(N_G1), .N_G2(N_G2), .N_D1(N_D1),
                        .N_D2(N_D2), .CNT_W(CNT_W), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .z_valid(z_valid), .z_ready(z_ready), .z_data(z_data),
    .gen_valid_in(gen_valid_in), .gen_z(gen_z),
    .flat_weights_L1(flat_weights_L1), .flat_weights_L2(flat_weights_L2),
    .flat_weights_D1(flat_weights_D1), .flat_weights_D2(flat_weights_D2),
    .gen_pix(gen_pix), .disc_done(disc_done), .disc_score(disc_score),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .weights_loaded(weights_loaded), .busy(busy), .err_timeout(err_timeout),
    .sample_cnt(sample_cnt), .score_sum(score_sum)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: word-level view of what the sequencer should hold.
  logic [DW-1:0]       m_w [N_W];
  logic [CNT_W-1:0]    m_cnt;
  logic [DW+CNT_W-1:0] m_sum;
  logic                m_err;
  logic [DW-1:0]       exp_q [NPIX+1];

  function automatic logic [DW+CNT_W-1:0] sum_exp();
`ifdef GAN_SCORE_SUM_EN
    return m_sum;
`else
    return '0;
`endif
  endfunction

  function automatic logic [DW-1:0] dut_word(input int i);
    logic [N_W*DW-1:0] wv;
    wv = {flat_weights_D2, flat_weights_D1, flat_weights_L2, flat_weights_L1};
    return wv[i*DW +: DW];
  endfunction

  task automatic model_reset();
    m_cnt = '0;
    m_sum = '0;
    m_err = 1'b0;
    for (int i = 0; i < N_W; i++) m_w[i] = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gen_valid"}, gen_valid_in, 0);
    check({tag, "_gen_z"}, gen_z, 0);
    check({tag, "_L1_zero"}, |flat_weights_L1, 0);
    check({tag, "_L2_zero"}, |flat_weights_L2, 0);
    check({tag, "_D1_zero"}, |flat_weights_D1, 0);
    check({tag, "_D2_zero"}, |flat_weights_D2, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_last"}, res_last, 0);
    check({tag, "_wl"}, weights_loaded, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_timeout, 0);
    check({tag, "_cnt"}, sample_cnt, 0);
    check({tag, "_sum"}, score_sum, 0);
    check({tag, "_z_ready"}, z_ready, 0);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push_cfg(input logic [DW-1:0] d);
    int guard = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = d;
    #1;
    check("cfg_prio_z_ready", z_ready, 0);
    while (!cfg_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!cfg_ready) check("cfg_hs_bound", 0, 1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic push_z(input logic [DW-1:0] d);
    int guard = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    z_valid = 1'b1;
    z_data  = d;
    #1;
    while (!z_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!z_ready) check("z_hs_bound", 0, 1);
    @(posedge clk);
    @(negedge clk);
    z_valid = 1'b0;
  endtask

  task automatic load_weights(input bit seq);
    logic [DW-1:0] nw [N_W];
    for (int i = 0; i < N_W; i++) nw[i] = seq ? DW'(i + 1) : DW'($urandom);
    for (int i = 0; i < N_W; i++) begin
      if (i == N_W - 1) check("wl_before_last", weights_loaded, 0);
      push_cfg(nw[i]);
      if (i == 0) begin
        check("wl_clear_on_load", weights_loaded, 0);
        m_sum = '0;
      end
      if (i == 10) begin
        check("old_word_kept", dut_word(40), m_w[40]);
        check("new_word_written", dut_word(10), nw[10]);
      end
      if (i < N_W - 1) check("z_ready_during_load", z_ready, 0);
    end
    check("wl_set", weights_loaded, 1);
    check("busy_after_load", busy, 0);
    for (int i = 0; i < N_W; i++) m_w[i] = nw[i];
    for (int i = 0; i < N_W; i++) check("weight_word", dut_word(i), m_w[i]);
  endtask

  task automatic collect(input int stall_at, input int stall_len, input bit rnd);
    int k = 0;
    int stalled = 0;
    int guard = 0;
    bit hs;
    while (k <= NPIX && guard < 300) begin
      guard++;
      if (k == stall_at && stalled < stall_len) begin
        res_ready = 1'b0;
        stalled++;
      end else begin
        res_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      check("res_valid", res_valid, 1);
      check("res_data", res_data, exp_q[k]);
      check("res_last", res_last, k == NPIX);
      hs = res_ready && res_valid;
      @(posedge clk);
      if (hs) k++;
      @(negedge clk);
    end
    res_ready = 1'b0;
    if (k <= NPIX) check("res_stream_bound", 0, 1);
    check("res_valid_after", res_valid, 0);
    check("busy_after", busy, 0);
    check("sample_cnt", sample_cnt, m_cnt);
    check("score_sum", score_sum, sum_exp());
    check("err_sticky", err_timeout, m_err);
  endtask

  task automatic run_sample(input logic [DW-1:0] z0, input logic [DW-1:0] z1, input int delay,
                            input bit no_done, input logic [DW-1:0] score, input bit tens,
                            input int stall_at, input int stall_len, input bit rnd);
    logic [NPIX*DW-1:0] pix;
    logic [DW-1:0] w;
    for (int k = 0; k < NPIX; k++) begin
      w = tens ? DW'((k + 1) * 10) : DW'($urandom);
      pix[k*DW +: DW] = w;
      exp_q[k] = w;
    end
    exp_q[NPIX] = score;
    push_z(z0);
    push_z(z1);
    check("gen_valid_fire", gen_valid_in, 1);
    check("gen_z", gen_z, {z1, z0});
    check("busy_fire", busy, 1);
    for (int j = 1; j <= (no_done ? TMO : delay); j++) begin
      @(negedge clk);
      check("gen_valid_once", gen_valid_in, 0);
      check("no_res_in_wait", res_valid, 0);
      check("err_in_wait", err_timeout, m_err);
    end
    if (no_done) begin
      @(negedge clk);
      m_err = 1'b1;
      check("err_set", err_timeout, 1);
      check("busy_after_tmo", busy, 0);
      check("no_res_after_tmo", res_valid, 0);
      check("cnt_after_tmo", sample_cnt, m_cnt);
      repeat (3) begin
        @(negedge clk);
        check("no_res_late", res_valid, 0);
      end
    end else begin
      disc_done  = 1'b1;
      gen_pix    = pix;
      disc_score = score;
      @(negedge clk);
      disc_done  = 1'b0;
      gen_pix    = ~pix;
      disc_score = ~score;
      m_cnt = m_cnt + 1'b1;
      m_sum = m_sum + {{CNT_W{score[DW-1]}}, score};
      collect(stall_at, stall_len, rnd);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    cfg_valid = 0; cfg_data = 0; z_valid = 0; z_data = 0;
    disc_done = 0; disc_score = 0; gen_pix = 0; res_ready = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("z_ready_unloaded", z_ready, 0);

    // Sequential weights 1..N_W
    load_weights(1'b1);
    check("tp_L1_w0", flat_weights_L1[15:0], 16'd1);
    check("tp_L2_w0", flat_weights_L2[15:0], 16'd10);
    check("tp_D1_w0", flat_weights_D1[15:0], 16'd46);
    check("tp_D2_w3", flat_weights_D2[63:48], 16'd79);

    // Fixed sample with pix k*10, score 0x1234, done 5 cycles after start
    run_sample(16'd100, 16'hFFCE, 5, 1'b0, 16'h1234, 1'b1, -1, 0, 1'b0);
    check("tp_cnt_one", sample_cnt, 1);
    // Stall three cycles on the fourth word
    run_sample(16'd7, 16'd8, 3, 1'b0, 16'h0042, 1'b1, 3, 3, 1'b0);
    // Done in the very cycle the timer would expire
    run_sample(16'h1111, 16'h2222, TMO, 1'b0, 16'h0BAD, 1'b0, -1, 0, 1'b1);
    // Timeout, then a normal sample still completes
    run_sample(16'h0001, 16'h0002, 0, 1'b1, 16'h0, 1'b0, -1, 0, 1'b0);
    run_sample(16'h0003, 16'h0004, 2, 1'b0, 16'h5555, 1'b0, -1, 0, 1'b1);
    // Randomized samples
    for (int s = 0; s < 6; s++)
      run_sample(DW'($urandom), DW'($urandom), $urandom_range(1, TMO), 1'b0, DW'($urandom),
                 1'b0, -1, 0, 1'b1);

    // Reset in the middle of WAIT; a late disc_done must be ignored
    push_z(DW'($urandom));
    push_z(DW'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("mid_wait");
    @(negedge clk);
    rst_n = 1'b1;
    disc_done  = 1'b1;
    gen_pix    = '1;
    disc_score = 16'h7777;
    @(negedge clk);
    disc_done = 1'b0;
    repeat (3) begin
      check("late_done_res", res_valid, 0);
      check("late_done_busy", busy, 0);
      @(negedge clk);
    end
    check("late_done_cnt", sample_cnt, 0);

    // Score accumulation: 5, -3, 0x7FFF, then a reload clears it
    load_weights(1'b0);
    run_sample(16'd1, 16'd2, 4, 1'b0, 16'd5, 1'b0, -1, 0, 1'b1);
    run_sample(16'd3, 16'd4, 1, 1'b0, 16'hFFFD, 1'b0, -1, 0, 1'b1);
    run_sample(16'd5, 16'd6, 6, 1'b0, 16'h7FFF, 1'b0, -1, 0, 1'b1);
`ifdef GAN_SCORE_SUM_EN
    check("tp_score_sum", score_sum, 32'd32769);
`else
    check("tp_score_sum_off", score_sum, 32'd0);
`endif
    check("tp_cnt_three", sample_cnt, 3);
    load_weights(1'b0);
    check("score_sum_reload", score_sum, 0);
    run_sample(DW'($urandom), DW'($urandom), 2, 1'b0, 16'h8000, 1'b0, -1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
